// File: rtl/ddr4_axi_fifo_arb_pkg.sv
// Shared definitions for the round-robin FIFO arbiter: FSM encoding and a
// constant-evaluable ceiling log2 used to size the source-ID field.
package ddr4_axi_fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLR   = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ddr4_v2_2_4_axi_fifo.sv
// Synchronous-reset FIFO with first-word fall-through: dout shows the head
// entry combinationally, so a read takes effect in the same cycle as rd_en.
module ddr4_v2_2_4_axi_fifo #(
  parameter int C_WIDTH  = 8,
  parameter int C_AWIDTH = 4,
  parameter int C_DEPTH  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [C_WIDTH-1:0] din,
  output logic               full,
  output logic               a_full,
  input  logic               rd_en,
  output logic [C_WIDTH-1:0] dout,
  output logic               empty,
  output logic               a_empty
);

  localparam logic [C_AWIDTH:0] AF_LVL = (C_AWIDTH+1)'(C_DEPTH - 1);
  localparam logic [C_AWIDTH:0] AE_LVL = (C_AWIDTH+1)'(1);

  logic [C_WIDTH-1:0] mem [C_DEPTH];
  logic [C_AWIDTH:0]  wr_ptr;
  logic [C_AWIDTH:0]  rd_ptr;
  logic [C_AWIDTH:0]  count;
  logic               do_wr;
  logic               do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr[C_AWIDTH] != rd_ptr[C_AWIDTH]) &&
                   (wr_ptr[C_AWIDTH-1:0] == rd_ptr[C_AWIDTH-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign a_full  = (count >= AF_LVL);
  assign a_empty = (count <= AE_LVL);
  assign do_wr   = wr_en && !full && !rst;
  assign do_rd   = rd_en && !empty && !rst;
  assign dout    = mem[rd_ptr[C_AWIDTH-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[C_AWIDTH-1:0]] <= din;
  end

endmodule

// File: rtl/ddr4_axi_fifo_rr_arb.sv
// Round-robin arbiter feeding one shared FIFO; each entry is tagged with its
// requester index. A small FSM provides drain-to-empty and one-cycle clear.
module ddr4_axi_fifo_rr_arb
  import ddr4_axi_fifo_arb_pkg::*;
#(
  parameter int C_NUM_REQ = 4,
  parameter int C_WIDTH   = 8,
  parameter int C_AWIDTH  = 4,
  parameter int C_DEPTH   = 16,
  localparam int C_IDW    = (clog2(C_NUM_REQ) > 1) ? clog2(C_NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [C_NUM_REQ-1:0]           req_valid,
  input  logic [C_NUM_REQ*C_WIDTH-1:0]   req_data,
  output logic [C_NUM_REQ-1:0]           req_ready,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [C_WIDTH-1:0]             m_data,
  output logic [C_IDW-1:0]               m_id,
  input  logic                           drain_req,
  input  logic                           clr_req,
  output logic                           drain_done,
  output logic [C_AWIDTH:0]              level,
  output logic                           busy,
  output state_t                         dbg_state
);

  // Handshake: a transfer happens on any cycle where valid and ready are both
  // high; valid never waits on ready, and ready may depend on valid.

  state_t                   state;
  logic [C_IDW-1:0]         ptr;
  logic                     rst_q;
  logic                     fifo_rst;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [C_NUM_REQ-1:0]     grant;
  logic [C_IDW-1:0]         gnt_idx;
  logic                     gnt_any;
  logic [C_IDW-1:0]         next_ptr;
  logic                     push;
  logic                     pop;
  logic [C_AWIDTH:0]        level_next;
  logic [C_WIDTH+C_IDW-1:0] fifo_din;
  logic [C_WIDTH+C_IDW-1:0] fifo_dout;
  logic [C_WIDTH-1:0]       payload [C_NUM_REQ];
  logic                     unused_a_full;
  logic                     unused_a_empty;

  for (genvar g = 0; g < C_NUM_REQ; g++) begin : g_payload
    assign payload[g] = req_data[g*C_WIDTH +: C_WIDTH];
  end

  // First asserted valid at or above ptr, wrapping around.
  always_comb begin
    int               idx;
    logic [C_IDW-1:0] idx_c;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    idx_c   = '0;
    for (int k = 0; k < C_NUM_REQ; k++) begin
      idx   = (int'(ptr) + k) % C_NUM_REQ;
      idx_c = C_IDW'(idx);
      if (!gnt_any && req_valid[idx_c]) begin
        grant[idx_c] = 1'b1;
        gnt_idx      = idx_c;
        gnt_any      = 1'b1;
      end
    end
  end

  assign next_ptr  = (gnt_idx == C_IDW'(C_NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign fifo_rst  = rst_q || (state == ST_CLR);
  assign req_ready = (state == ST_RUN && !fifo_full && !rst_q) ? grant : '0;
  assign push      = |(req_valid & req_ready);
  assign m_valid   = !fifo_empty && (state != ST_CLR) && !rst_q;
  assign pop       = m_valid && m_ready;
  assign fifo_din  = {gnt_idx, payload[gnt_idx]};
  assign m_data    = fifo_dout[C_WIDTH-1:0];
  assign m_id      = fifo_dout[C_WIDTH +: C_IDW];
  assign busy      = (state != ST_RUN) || (level != '0);
  assign dbg_state = state;

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // Held high from reset assertion until the first clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 1'b1;
    else        rst_q <= 1'b0;
  end

  // drain_done is keyed off level_next so it lands on the cycle level reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      ptr        <= '0;
      level      <= '0;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      if (push) ptr <= next_ptr;
      case (state)
        ST_RUN: begin
          level <= level_next;
          if (clr_req) begin
            state <= ST_CLR;
            level <= '0;
          end else if (drain_req) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          level <= level_next;
          if (clr_req) begin
            state <= ST_CLR;
            level <= '0;
          end else if (level_next == '0) begin
            drain_done <= 1'b1;
            state      <= ST_RUN;
          end
        end
        ST_CLR: begin
          level <= '0;
          state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  ddr4_v2_2_4_axi_fifo #(
    .C_WIDTH  (C_WIDTH + C_IDW),
    .C_AWIDTH (C_AWIDTH),
    .C_DEPTH  (C_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (fifo_rst),
    .wr_en   (push),
    .din     (fifo_din),
    .full    (fifo_full),
    .a_full  (unused_a_full),
    .rd_en   (pop),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .a_empty (unused_a_empty)
  );

endmodule
